// File: rtl/sseg_scan_decoder_if.sv
// Seven-segment scan bus: the scanned anode/cathode lines plus the decoded view a monitor rebuilds from them.
interface sseg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              sseg;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    pattern_err;
    logic                    anode_err;

    modport master (
        output an, sseg,
        input  digits, digit_valid, frame_valid, pattern_err, anode_err
    );

    modport slave (
        input  an, sseg,
        output digits, digit_valid, frame_valid, pattern_err, anode_err
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Receiver for a multiplexed active-low seven-segment bus: qualifies each stable digit slot,
// decodes the glyph back to a hex nibble and rebuilds the displayed value.
module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    sseg_scan_decoder_if.slave bus
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {QUALIFY, HOLD} state_t;

    state_t                  state_q;
    logic [SW-1:0]           s_q;
    logic [7:0]              cnt_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic                    frame_q;
    logic                    perr_q;
    logic                    aerr_q;

    logic [SW-1:0]         sample;
    logic                  stable;
    logic                  capture;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  any_low;
    logic                  multi_low;
    logic [IW-1:0]         idx;
    logic                  glyph_ok;
    logic                  blank;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] seen_d;

    assign sample    = {bus.an, bus.sseg};
    assign stable    = (sample == s_q);
    assign capture   = stable && (cnt_q == CNT_MAX - 8'd1);
    assign an_low    = ~bus.an;
    assign any_low   = |an_low;
    // Clearing the lowest set bit leaves something only when two or more anodes are driven.
    assign multi_low = |(an_low & (an_low - 1'b1));
    assign blank     = (bus.sseg == 7'h7F);
    assign seen_d    = seen_q | an_low;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) idx = IW'(i);
        end
    end

    always_comb begin
        glyph_ok = 1'b1;
        nib      = 4'h0;
        case (bus.sseg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h18: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= QUALIFY;
            s_q      <= '1;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            perr_q   <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            s_q     <= sample;
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
            aerr_q  <= 1'b0;
            if (!stable)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 8'd1;

            case (state_q)
                QUALIFY: begin
                    if (capture) begin
                        state_q <= HOLD;
                        if (multi_low) begin
                            aerr_q <= 1'b1;
                        end else if (any_low) begin
                            if (glyph_ok) begin
                                digits_q[4*idx +: 4] <= nib;
                                valid_q[idx]         <= 1'b1;
                            end else begin
                                valid_q[idx] <= 1'b0;
                                perr_q       <= !blank;
                            end
                            // A completed frame restarts the seen mask immediately.
                            if (&seen_d) begin
                                frame_q <= 1'b1;
                                seen_q  <= '0;
                            end else begin
                                seen_q  <= seen_d;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stable) state_q <= QUALIFY;
                end
                default: state_q <= QUALIFY;
            endcase
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.pattern_err = perr_q;
    assign bus.anode_err   = aerr_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboarded bench for sseg_scan_decoder: each qualifying slot pushes its expected result and cycle.
module tb_sseg_scan_decoder;
    localparam int N    = 4;
    localparam int S    = 4;
    localparam int HOLD = S + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sseg_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

    sseg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic        frm;
        logic        perr;
        logic        aerr;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_dig, h_dig, saved_dig;
    logic [3:0]  m_vld, m_seen, h_vld, saved_vld;
    logic [10:0] prev;
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_capture(input logic [3:0] an, input logic [6:0] ss, input int at);
        exp_t e;
        int   nlow = 0;
        int   idx  = 0;
        int   nib  = -1;
        for (int i = 0; i < N; i++) if (!an[i]) begin nlow++; idx = i; end
        if (nlow == 0) return;
        e.cyc = at; e.frm = 1'b0; e.perr = 1'b0; e.aerr = 1'b0;
        if (nlow > 1) begin
            e.aerr = 1'b1;
        end else begin
            for (int g = 0; g < 16; g++) if (glyph[g] == ss) nib = g;
            if (nib >= 0) begin
                m_dig[4*idx +: 4] = 4'(nib);
                m_vld[idx] = 1'b1;
            end else begin
                m_vld[idx] = 1'b0;
                e.perr = (ss != 7'h7F);
            end
            m_seen[idx] = 1'b1;
            if (&m_seen) begin e.frm = 1'b1; m_seen = '0; end
        end
        e.dig = m_dig;
        e.vld = m_vld;
        q.push_back(e);
    endtask

    // Drive one slot at negedge+1; it covers the next `hold` rising edges.
    task automatic slot(input logic [3:0] an, input logic [6:0] ss, input int hold);
        bus.an   = an;
        bus.sseg = ss;
        if (hold >= S + 1 && {an, ss} != prev) model_capture(an, ss, cyc + 1 + S);
        prev = {an, ss};
        repeat (hold) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        bus.an   = '1;
        bus.sseg = 7'h7F;
        m_dig = '0; m_vld = '0; m_seen = '0;
        prev  = {4'hF, 7'h7F};
        q.delete();
        repeat (n) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_digits", 32'(bus.digits), 32'h0);
            chk("rst_valid",  32'(bus.digit_valid), 32'h0);
            chk("rst_frame",  32'(bus.frame_valid), 32'h0);
            chk("rst_perr",   32'(bus.pattern_err), 32'h0);
            chk("rst_aerr",   32'(bus.anode_err), 32'h0);
            h_dig = '0;
            h_vld = '0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_capture_cycle", 32'(q[0].cyc), 32'(cyc));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_e = q.pop_front();
                chk("cap_digits", 32'(bus.digits), 32'(mon_e.dig));
                chk("cap_valid",  32'(bus.digit_valid), 32'(mon_e.vld));
                chk("cap_frame",  32'(bus.frame_valid), 32'(mon_e.frm));
                chk("cap_perr",   32'(bus.pattern_err), 32'(mon_e.perr));
                chk("cap_aerr",   32'(bus.anode_err), 32'(mon_e.aerr));
                h_dig = mon_e.dig;
                h_vld = mon_e.vld;
            end else begin
                chk("idle_digits", 32'(bus.digits), 32'(h_dig));
                chk("idle_valid",  32'(bus.digit_valid), 32'(h_vld));
                chk("idle_frame",  32'(bus.frame_valid), 32'h0);
                chk("idle_perr",   32'(bus.pattern_err), 32'h0);
                chk("idle_aerr",   32'(bus.anode_err), 32'h0);
            end
        end
    end

    initial begin
        do_reset(3);

        // Full scan with blanking gaps between digits
        slot(4'b1110, 7'h79, HOLD); slot(4'hF, 7'h7F, 2);
        slot(4'b1101, 7'h24, HOLD); slot(4'hF, 7'h7F, 2);
        slot(4'b1011, 7'h30, HOLD); slot(4'hF, 7'h7F, 2);
        slot(4'b0111, 7'h19, HOLD); slot(4'hF, 7'h7F, HOLD);
        chk("t1_digits", 32'(bus.digits), 32'h4321);
        chk("t1_valid",  32'(bus.digit_valid), 32'hF);

        // Every glyph on digit 0
        for (int g = 0; g < 16; g++) begin
            slot(4'b1110, glyph[g], HOLD);
            chk("t2_nibble", 32'(bus.digits[3:0]), 32'(g));
        end

        // Blank then illegal pattern
        slot(4'b1011, 7'h7F, HOLD);
        chk("t3_blank_valid", 32'(bus.digit_valid[2]), 32'h0);
        slot(4'b0111, 7'h55, HOLD);
        chk("t3_bad_valid", 32'(bus.digit_valid[3]), 32'h0);
        chk("t3_bad_digit", 32'(bus.digits[15:12]), 32'h4);

        // Glitch of exactly S edges, then S+1
        slot(4'b1101, 7'h30, S);
        chk("t4_glitch", 32'(bus.digits[7:4]), 32'h2);
        slot(4'hF, 7'h7F, HOLD);
        slot(4'b1101, 7'h30, S + 1);
        chk("t4_capture", 32'(bus.digits[7:4]), 32'h3);

        // Two anodes low, then all blank
        saved_dig = bus.digits;
        saved_vld = bus.digit_valid;
        slot(4'b1100, 7'h40, HOLD);
        chk("t5_digits", 32'(bus.digits), 32'(saved_dig));
        chk("t5_valid",  32'(bus.digit_valid), 32'(saved_vld));
        slot(4'hF, 7'h7F, HOLD);

        // Reset mid-scan with a slot pending, then a fresh frame
        slot(4'b1110, 7'h19, HOLD);
        slot(4'b1101, 7'h12, HOLD);
        slot(4'b1011, 7'h02, 2);
        do_reset(2);
        chk("t6_rst_digits", 32'(bus.digits), 32'h0);
        chk("t6_rst_valid",  32'(bus.digit_valid), 32'h0);
        slot(4'b1110, 7'h40, HOLD);
        slot(4'b1101, 7'h79, HOLD);
        slot(4'b1011, 7'h24, HOLD);
        slot(4'b0111, 7'h30, HOLD);
        slot(4'hF, 7'h7F, HOLD);
        chk("t6_digits", 32'(bus.digits), 32'h3210);
        chk("t6_valid",  32'(bus.digit_valid), 32'hF);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drain", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
